// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single RAM port arbiter between fetch (IF) and load/store (LS)
// Optional round-robin tie-break enabled with `define ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [1:0]        ls_size,
    output logic              ls_done,
    output logic              ls_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              cs,
    output logic              we,
    output logic              oe,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic [1:0]        data_size,
    input  logic [DATA_W-1:0] ram_data_into_mcu,
    input  logic              ram_ready
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [1:0]       SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [1:0]         size_q, size_d;
    logic               hold_we_q, hold_we_d;
    logic               owner_ls_q, owner_ls_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               grant_ls;

`ifdef ARB_ROUND_ROBIN_EN
    logic               last_ls_q, last_ls_d;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_ls = ls_req && (!if_req || !last_ls_q);
    end
`else
    always_comb begin
        grant_ls = ls_req;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SIZE_WORD;
            hold_we_q  <= 1'b0;
            owner_ls_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            hold_we_q  <= hold_we_d;
            owner_ls_q <= owner_ls_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ls_q <= 1'b0;
        end else begin
            last_ls_q <= last_ls_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        hold_we_d  = hold_we_q;
        owner_ls_d = owner_ls_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_ls_d  = last_ls_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ls_req || if_req) begin
                    state_d    = ST_BUSY;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    owner_ls_d = grant_ls;
`ifdef ARB_ROUND_ROBIN_EN
                    last_ls_d  = grant_ls;
`endif
                    if (grant_ls) begin
                        addr_d    = ls_addr;
                        wdata_d   = ls_wdata;
                        hold_we_d = ls_we;
                        size_d    = (ls_size == 2'b11) ? SIZE_WORD : ls_size;
                    end else begin
                        addr_d    = if_addr;
                        hold_we_d = 1'b0;
                        size_d    = SIZE_WORD;
                    end
                end
            end
            ST_BUSY: begin
                // A ready arriving on the timeout cycle still counts as success.
                if (ram_ready) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                    if (!hold_we_q) begin
                        rd_data_d = ram_data_into_mcu;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every port is a decode of registered state, so strobes never glitch mid-BUSY.
    always_comb begin
        cs          = (state_q == ST_BUSY);
        we          = cs & hold_we_q;
        oe          = cs & ~hold_we_q;
        address     = addr_q;
        ram_data_in = wdata_q;
        data_size   = size_q;
        if_done     = (state_q == ST_DONE) & ~owner_ls_q;
        ls_done     = (state_q == ST_DONE) & owner_ls_q;
        if_err      = if_done & err_q;
        ls_err      = ls_done & err_q;
        rd_data     = rd_data_q;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single external RAM port between two requesters: the instruction-fetch path (IF, loading IR from PC) and the load/store data path (LS, MAR/MWDR/MRDR traffic). It sits between the core's fetch and load/store sequencing and the RAM pins (`cs`/`we`/`oe`/address/data/`ram_ready`). It registers each granted transaction, holds the RAM strobes until `ram_ready`, returns read data with a one-cycle completion pulse, and aborts transactions that exceed a ready timeout.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, maximum BUSY cycles without `ram_ready` before abort; 0 disables the timeout
- `clk` input 1, system clock, rising edge
- `rst` input 1, asynchronous, active-high reset
- `if_req` input 1, fetch request; held until `if_done`
- `if_addr` input ADDR_W, fetch address
- `if_done` output 1, one-cycle fetch completion pulse
- `if_err` output 1, high with `if_done` when the fetch timed out
- `ls_req` input 1, load/store request; held until `ls_done`
- `ls_we` input 1, 1 = store, 0 = load
- `ls_addr` input ADDR_W, data address
- `ls_wdata` input DATA_W, store data
- `ls_size` input 2, 00 = byte, 01 = halfword, 10 = word, 11 = treated as word
- `ls_done` output 1, one-cycle load/store completion pulse
- `ls_err` output 1, high with `ls_done` when the access timed out
- `rd_data` output DATA_W, read data from the last completed successful read; held otherwise
- `cs`, `we`, `oe` output 1 each, RAM strobes
- `address` output ADDR_W, RAM address
- `ram_data_in` output DATA_W, write data to RAM
- `data_size` output 2, access size to RAM
- `ram_data_into_mcu` input DATA_W, read data from RAM
- `ram_ready` input 1, RAM completion; sampled only in BUSY

## Operation
- **States:** IDLE, BUSY, DONE. Encoding is free.
- **IDLE:**
  - If any request is pending, choose a winner using the priority rule below.
  - On the next edge, latch the winner's address, we, wdata and size into holding registers, record the owner, clear the timeout counter and enter BUSY.
  - Fetch transactions always use we=0 and size=10.
- **Priority:** LS beats IF when both are requesting (a data access belongs to the instruction in flight).
- **BUSY:**
  - Outputs: `cs`=1, `we`=held we, `oe`=!held we, `address`/`ram_data_in`/`data_size` = holding registers.
  - Outputs are stable for the whole of BUSY and are driven only from registers.
  - If `ram_ready`=1 at an edge: for a read, capture `ram_data_into_mcu` into `rd_data`; go to DONE with err=0.
  - Else, if TIMEOUT≠0 and the counter equals TIMEOUT−1: go to DONE with err=1. `rd_data` is unchanged.
  - Else: increment the counter (saturating).
  - If `ram_ready` arrives in the same cycle as the timeout, `ram_ready` wins.
- **DONE:**
  - Assert the owner's `*_done` (and `*_err` if flagged) for exactly one cycle, then return to IDLE.
  - `cs`=`we`=`oe`=0.
  - Requests are ignored in DONE; a requester drops `req` during its done cycle. A `req` still high in IDLE is a new request.
- **Request dropped during BUSY:** the transaction still completes and `done` still pulses.
- **`ram_ready` in IDLE or DONE:** ignored.
- **Strobes outside BUSY:** `cs`=`we`=`oe`=0. `address`, `ram_data_in` and `data_size` hold their last values.

## Timing
- **Reset (asynchronous):**
  - State becomes IDLE.
  - All strobes, `*_done` and `*_err` go to 0.
  - `address`, `ram_data_in` and `rd_data` go to 0; `data_size` goes to 10.
  - Timeout counter goes to 0; last-grant flag goes to IF.
- **Reset mid-transaction:** `cs` drops immediately without waiting for a clock edge. No `done` is issued; the requester must re-request.
- **Latency:**
  - `req` seen at edge 0 → BUSY (`cs`=1) from edge 0.
  - `ram_ready` sampled at edge k → `done` high from edge k until edge k+1.
  - IDLE at edge k+1.
- **Throughput:** minimum of 3 cycles per transaction (BUSY 1, DONE 1, IDLE 1).
- **Data validity:** `rd_data` is valid in the `done` cycle and is held until the next successful read completes.

## Configuration
- **`ARB_ROUND_ROBIN_EN` defined:**
  - When both requesters are pending in IDLE, the grant goes to the requester not granted last.
  - The last-grant flag updates on every grant and resets to IF, so LS wins the first tie.
  - A single pending requester is always granted.
- **`ARB_ROUND_ROBIN_EN` undefined:** fixed LS-over-IF priority; the last-grant flag is not implemented.

## Test plan
- **Fetch read:** reset, then `if_req`=1, `if_addr`=0x0000_0010; `ram_ready` goes high on the 3rd BUSY cycle with data 0xE3A0_1005 → `address`=0x10, `oe`=1, `we`=0, `data_size`=10; `if_done` pulses once; `rd_data`=0xE3A0_1005; `ls_done` never asserts.
- **Store byte:** `ls_req`, `ls_we`=1, `ls_addr`=0x200, `ls_wdata`=0xAB, `ls_size`=00; `ram_ready` in the 1st BUSY cycle → `we`=1, `oe`=0, `ram_data_in`=0xAB, `data_size`=00; `ls_done` 2 cycles after the request; `rd_data` unchanged.
- **Contention:** `if_req` and `ls_req` rise together, `ram_ready` tied high.
  - Without the macro: LS served first, IF served next, IF serviced within 6 cycles.
  - With `ARB_ROUND_ROBIN_EN` and both held continuously: grants alternate LS, IF, LS, IF.
- **Timeout:** TIMEOUT=4, `ram_ready`=0, `ls_req` load → `cs` high exactly 4 cycles, then `ls_done`=`ls_err`=1 for one cycle; `rd_data` unchanged.
- **Ready/timeout collision:** TIMEOUT=4 with `ram_ready` high in the 4th BUSY cycle → `ls_err`=0, data captured.
- **Reset mid-BUSY:** assert `rst` in the 2nd BUSY cycle → `cs`=0 in the same cycle; no `done`; after reset release a new `if_req` is granted normally.
